// File: rtl/romtile_arb.sv
// romtile_arb: round-robin tile-ROM read server.
// NCH requesters share one synchronous ROM port (read latency LAT). Each grant
// issues a registered ROM read, a LAT+1 deep tag pipeline follows the read, and
// the returned W-bit word is expanded into W 4-bit pixel fields on the ack cycle.
// Optional feature: define ROMTILE_HFLIP_EN to add the per-channel hflip input,
// which reverses the pixel field order for that read.
module romtile_arb #(
  parameter int NCH = 2,
  parameter int AW  = 13,
  parameter int W   = 4,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] addr,
`ifdef ROMTILE_HFLIP_EN
  input  logic [NCH-1:0]    hflip,
`endif
  output logic [NCH-1:0]    ack,
  output logic [4*W-1:0]    data,
  output logic              rom_rd,
  output logic [AW-2:0]     rom_addr,
  input  logic [W-1:0]      rom_data
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  function automatic logic [NCH-1:0] onehot(input logic [PW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NCH-1:0]  busy_q, busy_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [4*W-1:0]  data_q, data_d;
  logic            rom_rd_q, rom_rd_d;
  logic [AW-2:0]   rom_addr_q, rom_addr_d;
  logic [LAT:0]    tv_q, tv_d;
  logic [PW-1:0]   tch_q [LAT+1];
  logic [PW-1:0]   tch_d [LAT+1];

  logic            gnt_any;
  logic [PW-1:0]   gnt_id;
  logic [NCH-1:0]  elig;
  logic [AW-1:0]   a_g;
  int unsigned     idx;
  logic            flip;
  logic [4*W-1:0]  pix_nf;

  // Round-robin search: first eligible channel at or after the pointer
  always_comb begin
    elig    = req & ~busy_q;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NCH; off++) begin
      idx = (32'(ptr_q) + off) % NCH;
      if (!gnt_any && elig[PW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = PW'(idx);
      end
    end
  end

  // Pick the granted channel's address
  always_comb begin
    a_g = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_id == PW'(i)) a_g = addr[i*AW +: AW];
    end
  end

  // Pixel expansion: pixel 0 (low field) comes from the ROM MSB
  for (genvar k = 0; k < W; k++) begin : g_exp
    assign pix_nf[4*k +: 4] = {3'b000, rom_data[W-1-k]};
  end

`ifdef ROMTILE_HFLIP_EN
  logic [LAT:0]   tfl_q, tfl_d;
  logic [4*W-1:0] pix_fl;

  for (genvar k = 0; k < W; k++) begin : g_expf
    assign pix_fl[4*k +: 4] = {3'b000, rom_data[k]};
  end

  // hflip travels alongside the tag of its read
  always_comb begin
    tfl_d = {tfl_q[LAT-1:0], hflip[gnt_id]};
    flip  = tfl_q[LAT];
  end

  // hflip tag register
  always_ff @(posedge clk) begin
    if (rst) tfl_q <= '0;
    else     tfl_q <= tfl_d;
  end
`else
  assign flip = 1'b0;
`endif

  // Next state: pointer, busy mask, ROM strobe, tag shift and ack/data stage
  always_comb begin
    ptr_d      = ptr_q;
    busy_d     = busy_q & ~ack_q;
    rom_rd_d   = gnt_any;
    rom_addr_d = rom_addr_q;
    tv_d       = {tv_q[LAT-1:0], gnt_any};
    tch_d[0]   = gnt_id;
    for (int unsigned j = 1; j <= LAT; j++) tch_d[j] = tch_q[j-1];
    ack_d      = '0;
    data_d     = data_q;
    if (gnt_any) begin
      ptr_d      = (32'(gnt_id) == NCH - 1) ? '0 : gnt_id + 1'b1;
      busy_d     = busy_d | onehot(gnt_id);
      rom_addr_d = {a_g[AW-1:5], a_g[2:0], ~a_g[4]};
    end
    if (tv_q[LAT]) begin
      ack_d  = onehot(tch_q[LAT]);
`ifdef ROMTILE_HFLIP_EN
      data_d = flip ? pix_fl : pix_nf;
`else
      data_d = flip ? '0 : pix_nf;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      busy_q     <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      tv_q       <= '0;
      for (int unsigned j = 0; j <= LAT; j++) tch_q[j] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      tv_q       <= tv_d;
      for (int unsigned j = 0; j <= LAT; j++) tch_q[j] <= tch_d[j];
    end
  end

  assign ack      = ack_q;
  assign data     = data_q;
  assign rom_rd   = rom_rd_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_romtile_arb.sv
// Directed bench for romtile_arb: a 2-channel LAT=1 instance and a
// 4-channel LAT=3 instance, each fed by a small ROM model (word = addr[3:0]^4'hC).
module tb_romtile_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NCH=2, LAT=1
  logic [1:0]  req_a;
  logic [25:0] addr_a;
  logic [1:0]  ack_a;
  logic [15:0] data_a;
  logic        rom_rd_a;
  logic [11:0] rom_addr_a;
  logic [3:0]  rom_data_a;
  // Instance B: NCH=4, LAT=3
  logic [3:0]  req_b;
  logic [51:0] addr_b;
  logic [3:0]  ack_b;
  logic [15:0] data_b;
  logic        rom_rd_b;
  logic [11:0] rom_addr_b;
  logic [3:0]  rom_data_b;
  logic [3:0]  pb0, pb1, pb2;
`ifdef ROMTILE_HFLIP_EN
  logic [1:0]  hflip_a;
  logic [3:0]  hflip_b;
`endif

  romtile_arb #(.NCH(2), .AW(13), .W(4), .LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .addr(addr_a),
`ifdef ROMTILE_HFLIP_EN
    .hflip(hflip_a),
`endif
    .ack(ack_a), .data(data_a), .rom_rd(rom_rd_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a)
  );

  romtile_arb #(.NCH(4), .AW(13), .W(4), .LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .addr(addr_b),
`ifdef ROMTILE_HFLIP_EN
    .hflip(hflip_b),
`endif
    .ack(ack_b), .data(data_b), .rom_rd(rom_rd_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b)
  );

  function automatic logic [3:0] rom_fn(input logic [11:0] a);
    return a[3:0] ^ 4'hC;
  endfunction

  // ROM models: data valid exactly LAT cycles after rom_rd
  always @(posedge clk) rom_data_a <= rom_fn(rom_addr_a);
  always @(posedge clk) begin
    pb0 <= rom_fn(rom_addr_b);
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rom_data_b = pb2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One isolated read on instance A
  task automatic single_a(input int ch, input logic [12:0] a,
                          input logic [11:0] era, input logic [15:0] ed);
    req_a[ch] = 1'b1;
    addr_a[ch*13 +: 13] = a;
    chk("s_rd_grant", 32'(rom_rd_a), 0);
    step();
    addr_a[ch*13 +: 13] = 13'h1FFF;
    chk("s_rd", 32'(rom_rd_a), 1);
    chk("s_raddr", 32'(rom_addr_a), 32'(era));
    chk("s_ack1", 32'(ack_a), 0);
    step();
    chk("s_ack2", 32'(ack_a), 0);
    chk("s_rd2", 32'(rom_rd_a), 0);
    step();
    chk("s_ack", 32'(ack_a), 32'(2'b01 << ch));
    chk("s_data", 32'(data_a), 32'(ed));
    req_a[ch] = 1'b0;
    step();
    chk("s_ack_off", 32'(ack_a), 0);
    chk("s_data_hold", 32'(data_a), 32'(ed));
  endtask

  // Both channels of A request together; f is the channel expected first
  task automatic pair_a(input int f);
    logic [11:0] ra [2];
    logic [15:0] dd [2];
    int s;
    ra[0] = 12'h004; dd[0] = 16'h0001;
    ra[1] = 12'h01A; dd[1] = 16'h0110;
    s = 1 - f;
    addr_a = {13'h0035, 13'h0012};
    req_a  = 2'b11;
    step();
    chk("p_rd1", 32'(rom_rd_a), 1);
    chk("p_raddr1", 32'(rom_addr_a), 32'(ra[f]));
    step();
    chk("p_rd2", 32'(rom_rd_a), 1);
    chk("p_raddr2", 32'(rom_addr_a), 32'(ra[s]));
    chk("p_ack0", 32'(ack_a), 0);
    step();
    chk("p_ack_first", 32'(ack_a), 32'(2'b01 << f));
    chk("p_data_first", 32'(data_a), 32'(dd[f]));
    req_a[f] = 1'b0;
    step();
    chk("p_ack_second", 32'(ack_a), 32'(2'b01 << s));
    chk("p_data_second", 32'(data_a), 32'(dd[s]));
    chk("p_rd_idle", 32'(rom_rd_a), 0);
    req_a[s] = 1'b0;
    step();
    chk("p_ack_off", 32'(ack_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ra_b [4];
    logic [15:0] d_b [4];
    ra_b[0] = 12'h004; d_b[0] = 16'h0001;
    ra_b[1] = 12'h01A; d_b[1] = 16'h0110;
    ra_b[2] = 12'h001; d_b[2] = 16'h1011;
    ra_b[3] = 12'h001; d_b[3] = 16'h1011;

    rst = 1'b1;
    req_a = '0; addr_a = '0; req_b = '0; addr_b = '0;
`ifdef ROMTILE_HFLIP_EN
    hflip_a = '0; hflip_b = '0;
`endif
    repeat (3) step();
    chk("rst_ack_a", 32'(ack_a), 0);
    chk("rst_data_a", 32'(data_a), 0);
    chk("rst_rd_a", 32'(rom_rd_a), 0);
    chk("rst_raddr_a", 32'(rom_addr_a), 0);
    chk("rst_ack_b", 32'(ack_b), 0);
    chk("rst_rd_b", 32'(rom_rd_b), 0);
    rst = 1'b0;
    step();

    // Single reads: remap, expansion, address bit 3 ignored
    single_a(0, 13'h0012, 12'h004, 16'h0001);
    single_a(1, 13'h0035, 12'h01A, 16'h0110);
    single_a(0, 13'h0008, 12'h001, 16'h1011);
    single_a(0, 13'h0000, 12'h001, 16'h1011);

    // Pointer is 1 after a ch0 grant: ch1 wins the tie
    pair_a(1);
    // After reset the pointer is 0: ch0 first, and the pointer wraps back to 0
    rst_pulse();
    pair_a(0);
    pair_a(0);

    // Held request on ch0: one read and one ack every 4 cycles
    addr_a[12:0] = 13'h0012;
    req_a[0] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      chk("h_ack", 32'(ack_a), (c % 4 == 3) ? 32'd1 : 32'd0);
      chk("h_rd", 32'(rom_rd_a), (c % 4 == 1) ? 32'd1 : 32'd0);
    end
    req_a[0] = 1'b0;
    step();
    chk("h_ack_end", 32'(ack_a), 0);
    chk("h_rd_end", 32'(rom_rd_a), 0);

    // Reset while a read is in flight: returning ROM data is discarded
    addr_a[12:0] = 13'h0012;
    req_a[0] = 1'b1;
    step();
    chk("r_rd", 32'(rom_rd_a), 1);
    step();
    rst = 1'b1;
    req_a[0] = 1'b0;
    step();
    rst = 1'b0;
    chk("r_ack0", 32'(ack_a), 0);
    chk("r_rd0", 32'(rom_rd_a), 0);
    chk("r_data0", 32'(data_a), 0);
    step();
    chk("r_ack1", 32'(ack_a), 0);
    step();
    chk("r_ack2", 32'(ack_a), 0);
    single_a(0, 13'h0012, 12'h004, 16'h0001);

    // Instance B: four channels at LAT=3, all requesting together
    addr_b = {13'h0000, 13'h0008, 13'h0035, 13'h0012};
    req_b  = 4'b1111;
    chk("b_rd0", 32'(rom_rd_b), 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c <= 4) begin
        chk("b_rd", 32'(rom_rd_b), 1);
        chk("b_raddr", 32'(rom_addr_b), 32'(ra_b[c-1]));
      end else begin
        chk("b_rd_idle", 32'(rom_rd_b), 0);
      end
      if (c >= 5) begin
        chk("b_ack", 32'(ack_b), 32'(4'b0001 << (c - 5)));
        chk("b_data", 32'(data_b), 32'(d_b[c-5]));
        req_b[c-5] = 1'b0;
      end else begin
        chk("b_ack_early", 32'(ack_b), 0);
      end
    end
    step();
    chk("b_ack_end", 32'(ack_b), 0);

`ifdef ROMTILE_HFLIP_EN
    // Horizontal flip reverses the pixel field order
    hflip_a[0] = 1'b1;
    single_a(0, 13'h0012, 12'h004, 16'h1000);
    hflip_a[0] = 1'b0;
    single_a(0, 13'h0012, 12'h004, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
